gauss_output_stage: RTL and testbench

- Final Box-Muller stage, directly downstream of logAndSquareUnit.
- Consumes one magnitude f = sqrt(-2 ln u0) together with the matching trig pair g0 = cos(2*pi*u1) and g1 = sin(2*pi*u1).
- Produces two Gaussian samples, x0 = f*g0 then x1 = f*g1, through a pipelined multiply/round path and an output FIFO with a valid/ready handshake.

---
 rtl/gauss_pkg.sv | 18 +
 rtl/gauss_out_fifo.sv | 65 ++++++
 rtl/gauss_output_stage.sv | 138 +++++++++++++
 tb/tb_gauss_output_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared widths, fixed-point formats and the sample type for the Box-Muller output stage.
package gauss_pkg;

   localparam int F_W    = 16;
   localparam int G_W    = 16;
   localparam int OUT_W  = 16;
   localparam int PROD_W = 33;

   localparam int F_FRAC   = 13;
   localparam int G_FRAC   = 14;
   localparam int OUT_FRAC = 11;

   // Product carries F_FRAC + G_FRAC = 27 fractional bits; dropping 16 leaves Q5.11.
   localparam int OUT_SHIFT_DEFAULT = F_FRAC + G_FRAC - OUT_FRAC;

   typedef logic signed [OUT_W-1:0] sample_t;

endpackage

// File: rtl/gauss_out_fifo.sv
// Dual-write, single-read synchronous FIFO: each push writes a pair into two adjacent slots.
// Pairs always start on an even slot, so the read pointer LSB tells which half of a pair is at the head.
module gauss_out_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_wdata0,
   input  logic [W-1:0]     i_wdata1,
   input  logic             i_pop,
   output logic [W-1:0]     o_rdata,
   output logic [CNT_W-1:0] o_count,
   output logic             o_headOdd
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign w_pop = i_pop && (r_count != '0);

   // The write pointer is always even, so the second slot of a pair never wraps.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wrPtr]               <= i_wdata0;
         r_mem[r_wrPtr + PTR_W'(1)]   <= i_wdata1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 2)) ? '0 : r_wrPtr + PTR_W'(2);
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(2);
            2'b11:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata   = (r_count != '0) ? r_mem[r_rdPtr] : '0;
   assign o_count   = r_count;
   assign o_headOdd = r_rdPtr[0];

   overflowCheck: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_push |-> ((int'(r_count) + 2 - int'(w_pop)) <= DEPTH));

endmodule

// File: rtl/gauss_output_stage.sv
// Final Box-Muller stage: x0 = f*cos, x1 = f*sin, scaled to Q5.11 and buffered for a valid/ready consumer.
// Build option GAUSS_OUT_ROUND_EN selects round-half-up; otherwise results truncate toward minus infinity.
module gauss_output_stage
   import gauss_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int OUT_SHIFT  = OUT_SHIFT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [F_W-1:0]   f_i,
   input  logic [G_W-1:0]   g0_i,
   input  logic [G_W-1:0]   g1_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] sample_o,
   output logic [31:0]      pair_cnt_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                     r_s1Valid;
   logic [F_W-1:0]           r_f;
   logic signed [G_W-1:0]    r_g0;
   logic signed [G_W-1:0]    r_g1;
   logic                     r_s2Valid;
   logic signed [PROD_W-1:0] r_p0;
   logic signed [PROD_W-1:0] r_p1;
   logic                     r_s3Valid;
   sample_t                  r_x0;
   sample_t                  r_x1;
   logic [31:0]              r_pairCnt;

   logic                     w_accept;
   logic                     w_pop;
   logic                     w_popIsX1;
   logic [CNT_W-1:0]         w_fifoCount;
   int                       w_used;
   logic signed [PROD_W-1:0] w_fWide;
   logic signed [PROD_W-1:0] w_g0Wide;
   logic signed [PROD_W-1:0] w_g1Wide;
   logic signed [PROD_W-1:0] w_p0Adj;
   logic signed [PROD_W-1:0] w_p1Adj;
   sample_t                  w_x0;
   sample_t                  w_x1;

   // Every stage holding a pair reserves two FIFO slots, so the FIFO can never overflow
   // and the pipeline never needs to stall.
   always_comb begin
      w_used   = int'(w_fifoCount)
               + 2 * (int'(r_s1Valid) + int'(r_s2Valid) + int'(r_s3Valid));
      in_ready = reset && (w_used <= FIFO_DEPTH - 2);
   end

   assign w_accept = in_valid && in_ready;

   assign w_fWide  = PROD_W'({1'b0, r_f});
   assign w_g0Wide = PROD_W'(r_g0);
   assign w_g1Wide = PROD_W'(r_g1);

`ifdef GAUSS_OUT_ROUND_EN
   localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(64'd1 << (OUT_SHIFT - 1));
   assign w_p0Adj = r_p0 + ROUND_BIAS;
   assign w_p1Adj = r_p1 + ROUND_BIAS;
`else
   assign w_p0Adj = r_p0;
   assign w_p1Adj = r_p1;
`endif

   // |f| < 8 and g in [-2,2) keep the shifted result inside 16 bits, so no saturation is needed.
   assign w_x0 = OUT_W'(w_p0Adj >>> OUT_SHIFT);
   assign w_x1 = OUT_W'(w_p1Adj >>> OUT_SHIFT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1Valid <= 1'b0;
         r_f       <= '0;
         r_g0      <= '0;
         r_g1      <= '0;
         r_s2Valid <= 1'b0;
         r_p0      <= '0;
         r_p1      <= '0;
         r_s3Valid <= 1'b0;
         r_x0      <= '0;
         r_x1      <= '0;
      end else begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_f  <= f_i;
            r_g0 <= g0_i;
            r_g1 <= g1_i;
         end
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_p0 <= w_fWide * w_g0Wide;
            r_p1 <= w_fWide * w_g1Wide;
         end
         r_s3Valid <= r_s2Valid;
         if (r_s2Valid) begin
            r_x0 <= w_x0;
            r_x1 <= w_x1;
         end
      end
   end

   gauss_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (OUT_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_push    (r_s3Valid),
      .i_wdata0  (r_x0),
      .i_wdata1  (r_x1),
      .i_pop     (w_pop),
      .o_rdata   (sample_o),
      .o_count   (w_fifoCount),
      .o_headOdd (w_popIsX1)
   );

   assign out_valid = (w_fifoCount != '0);
   assign w_pop     = out_valid && out_ready;

   // A pair counts as drained when its x1 (odd slot) leaves the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pairCnt <= '0;
      end else if (w_pop && w_popIsX1) begin
         r_pairCnt <= r_pairCnt + 32'd1;
      end
   end

   assign pair_cnt_o = r_pairCnt;

endmodule

// File: tb/tb_gauss_output_stage.sv
// Self-checking bench for gauss_output_stage: directed pairs, backpressure, random throttle, mid-stream reset.
// Expected values follow GAUSS_OUT_ROUND_EN when the bench is built with it.
module tb_gauss_output_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] f_i;
   logic [15:0] g0_i;
   logic [15:0] g1_i;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sample_o;
   logic [31:0] pair_cnt_o;

   int checks = 0;
   int errors = 0;

`ifdef GAUSS_OUT_ROUND_EN
   localparam logic [15:0] RND_X0 = 16'h0001;
   localparam logic [15:0] RND_X1 = 16'h0000;
   localparam logic [15:0] EXT_X0 = 16'h7FFF;
   localparam logic [15:0] EXT_X1 = 16'h8001;
`else
   localparam logic [15:0] RND_X0 = 16'h0000;
   localparam logic [15:0] RND_X1 = 16'hFFFF;
   localparam logic [15:0] EXT_X0 = 16'h7FFE;
   localparam logic [15:0] EXT_X1 = 16'h8000;
`endif

   gauss_output_stage #(
      .FIFO_DEPTH (8),
      .OUT_SHIFT  (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .f_i        (f_i),
      .g0_i       (g0_i),
      .g1_i       (g1_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sample_o   (sample_o),
      .pair_cnt_o (pair_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned f times signed g, optional half-LSB bias, arithmetic shift by 16.
   function automatic logic [15:0] refSample(input logic [15:0] f, input logic [15:0] g);
      longint p;
      p = longint'(f) * longint'($signed(g));
`ifdef GAUSS_OUT_ROUND_EN
      p = p + 64'sd32768;
`endif
      p = p >>> 16;
      return p[15:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Hold one pair on the input until it is accepted; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [15:0] f, input logic [15:0] g0, input logic [15:0] g1);
      int waitCyc = 0;
      f_i      = f;
      g0_i     = g0;
      g1_i     = g1;
      in_valid = 1'b1;
      while (!in_ready && waitCyc < 50) begin
         @(posedge clk); #1;
         waitCyc++;
      end
      checkOutput("accept_wait", 32'(waitCyc < 50), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // One pair through an empty FIFO with out_ready held high: x0 after the third edge, x1 one cycle later.
   task automatic runPair(input string tag, input logic [15:0] f, input logic [15:0] g0,
                          input logic [15:0] g1, input logic [15:0] e0, input logic [15:0] e1,
                          input int expPairs);
      out_ready = 1'b1;
      applyStimulus(f, g0, g1);
      checkOutput({tag, "_valid_n0"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid_n1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid_n2"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid_n3"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_x0"}, 32'(sample_o), 32'(e0));
      @(posedge clk); #1;
      checkOutput({tag, "_valid_n4"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_x1"}, 32'(sample_o), 32'(e1));
      @(posedge clk); #1;
      checkOutput({tag, "_valid_n5"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_pairs"}, pair_cnt_o, 32'(expPairs));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] bpQ[$];
      logic [15:0] qExp[$];
      int          accepted;
      int          got;
      int          cyc;
      bit          sawReady;
      bit          holding;
      bit          doAccept;
      bit          doPop;

      in_valid  = 1'b0;
      out_ready = 1'b0;
      f_i       = '0;
      g0_i      = '0;
      g1_i      = '0;
      reset     = 1'b1;
      #1 reset  = 1'b0;
      #3;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_sample", 32'(sample_o), 32'd0);
      checkOutput("rst_pair_cnt", pair_cnt_o, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

      runPair("basic", 16'h2000, 16'h2000, 16'hE000, 16'h0400, 16'hFC00, 1);
      runPair("round", 16'h0002, 16'h4000, 16'hC000, RND_X0, RND_X1, 2);
      runPair("extreme", 16'hFFFF, 16'h7FFF, 16'h8000, EXT_X0, EXT_X1, 3);

      // Backpressure: consumer stalled, producer always valid.
      $display("[TB] backpressure");
      doReset();
      out_ready = 1'b0;
      accepted  = 0;
      for (int c = 0; c < 16; c++) begin
         f_i      = 16'(32'h2000 + accepted * 32'h0111);
         g0_i     = 16'(accepted * 32'h0900 + 32'h0100);
         g1_i     = 16'(0 - accepted * 32'h0700 - 32'h0300);
         in_valid = 1'b1;
         sawReady = in_ready;
         if (sawReady) begin
            bpQ.push_back(refSample(f_i, g0_i));
            bpQ.push_back(refSample(f_i, g1_i));
         end
         @(posedge clk); #1;
         if (sawReady) accepted++;
      end
      in_valid = 1'b0;
      checkOutput("bp_accepted", 32'(accepted), 32'd4);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 8; c++) begin
         if (out_valid && bpQ.size() != 0) begin
            checkOutput($sformatf("bp_sample%0d", got), 32'(sample_o), 32'(bpQ.pop_front()));
            got++;
         end
         @(posedge clk); #1;
      end
      checkOutput("bp_samples_drained", 32'(got), 32'd8);
      checkOutput("bp_pair_cnt", pair_cnt_o, 32'd4);
      checkOutput("bp_in_ready_resume", 32'(in_ready), 32'd1);
      checkOutput("bp_empty", 32'(out_valid), 32'd0);

      // Random throttle against the reference model.
      $display("[TB] random throttle");
      accepted = 0;
      cyc      = 0;
      holding  = 1'b0;
      while ((accepted < 1000 || qExp.size() != 0) && cyc < 30000) begin
         if (!holding && accepted < 1000 && $urandom_range(0, 3) != 0) begin
            f_i      = 16'($urandom);
            g0_i     = 16'($urandom);
            g1_i     = 16'($urandom);
            in_valid = 1'b1;
            holding  = 1'b1;
         end
         out_ready = (accepted >= 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
         doAccept  = in_valid && in_ready;
         doPop     = out_valid && out_ready;
         if (doPop) begin
            checkOutput("rand_pop_expected", 32'(qExp.size() != 0), 32'd1);
            if (qExp.size() != 0) begin
               checkOutput($sformatf("rand_sample_c%0d", cyc), 32'(sample_o), 32'(qExp.pop_front()));
            end
         end
         if (doAccept) begin
            qExp.push_back(refSample(f_i, g0_i));
            qExp.push_back(refSample(f_i, g1_i));
         end
         @(posedge clk); #1;
         cyc++;
         if (doAccept) begin
            accepted++;
            in_valid = 1'b0;
            holding  = 1'b0;
         end
      end
      checkOutput("rand_completed", 32'(cyc < 30000), 32'd1);
      checkOutput("rand_queue_empty", 32'(qExp.size()), 32'd0);
      checkOutput("rand_pair_cnt", pair_cnt_o, 32'd1004);

      // Reset with 3 samples buffered and 2 pairs in flight.
      $display("[TB] reset mid-stream");
      doReset();
      out_ready = 1'b0;
      applyStimulus(16'h1000, 16'h1234, 16'h4321);
      applyStimulus(16'h3000, 16'hF000, 16'h0800);
      applyStimulus(16'h5555, 16'h2AAA, 16'hD555);
      repeat (4) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      checkOutput("mid_pre_pair_cnt", pair_cnt_o, 32'd1);
      checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
      applyStimulus(16'h7000, 16'h3000, 16'hC800);
      applyStimulus(16'h0800, 16'h7FFF, 16'h8000);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_sample", 32'(sample_o), 32'd0);
      checkOutput("mid_rst_pair_cnt", pair_cnt_o, 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      runPair("post_rst", 16'h2000, 16'h2000, 16'hE000, 16'h0400, 16'hFC00, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
